// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder built from two half adders, stepped LSB-first over WIDTH bits.
// Optional subtract mode when SERIAL_ADDER_SUB_EN is defined (adds the sub input).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [CW-1:0]    cnt;
  logic             cy;

  logic             hs1, hc1, sum, hc2, cy_nxt;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] b_ld;
  logic             cy_ld;

  always_comb begin
    hs1    = a_sr[0] ^ b_sr[0];
    hc1    = a_sr[0] & b_sr[0];
    sum    = hs1 ^ cy;
    hc2    = hs1 & cy;
    cy_nxt = hc1 | hc2;
    // Sum bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
    r_nxt  = {sum, r_sr};
  end

`ifdef SERIAL_ADDER_SUB_EN
  // A - B computed as A + ~B + 1.
  assign b_ld  = sub ? ~B : B;
  assign cy_ld = sub;
`else
  assign b_ld  = B;
  assign cy_ld = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      cnt   <= '0;
      cy    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      C     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= A;
            b_sr  <= b_ld;
            cy    <= cy_ld;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sr <= r_nxt[WIDTH:1];
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          cy   <= cy_nxt;
          cnt  <= cnt + CW'(1);
          // S/C are only written here, so the previous result stays visible during RUN.
          if (cnt == LAST) begin
            S     <= r_nxt[WIDTH:1];
            C     <= cy_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
